mgmt_host_bridge: RTL and testbench
===================================

Name: mgmt_host_bridge

Overview:
- Upstream front-end for the 10G MAC management block.
- Converts a simple valid/ready host request channel (CPU or bus slave) into the management port's transaction sequence: mgmt_opcode, mgmt_addr, mgmt_wr_data, mgmt_miim_sel, a one-cycle mgmt_req, and mgmt_miim_rdy tracking.
- Returns read data or a write acknowledge as a single-cycle response, with optional timeout on stalled MDIO transactions.
- Serialises all accesses; one transaction is outstanding at a time.

Parameters:
- RD_LAT, 2, mgmt_clk cycles from mgmt_req to valid mgmt_rd_data for config/statistics (non-MIIM) accesses; legal range 1..15.
- RDY_LOW_WAIT, 4, max cycles after mgmt_req to observe mgmt_miim_rdy deassert on MIIM access.
- TIMEOUT_CYC, 4096, MIIM completion timeout in cycles from mgmt_req (used only with the optional feature); 16-bit counter.

Ports:
- mgmt_clk  in  1  management clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- host_valid  in  1  request valid.
- host_ready  out  1  bridge can accept request.
- host_opcode  in  2  management opcode, passed through; bit1=1 means read.
- host_addr  in  10  register address.
- host_miim_sel  in  1  0=config/stats register, 1=MDIO.
- host_wdata  in  32  write data.
- host_rvalid  out  1  one-cycle response strobe.
- host_rdata  out  32  read data (0 for writes and errors).
- host_rerr  out  1  response error flag (timeout), valid with host_rvalid.
- mgmt_opcode  out  2  to management block.
- mgmt_addr  out  10  to management block.
- mgmt_wr_data  out  32  to management block.
- mgmt_miim_sel  out  1  to management block.
- mgmt_req  out  1  one-cycle request pulse.
- mgmt_rd_data  in  32  from management block.
- mgmt_miim_rdy  in  1  from management block; high when MDIO idle.

Behaviour:
- Reset: state IDLE; host_ready=0 in the reset cycle, then follows the IDLE rule; host_rvalid=0, host_rdata=0, host_rerr=0, mgmt_req=0, mgmt_opcode=0, mgmt_addr=0, mgmt_wr_data=0, mgmt_miim_sel=0; counters cleared. Reset mid-transaction aborts it with no response.
- All outputs registered.
- host_ready=1 only in IDLE while mgmt_miim_rdy=1 (registered, so at most one cycle stale; a request accepted in a stale cycle waits in ISSUE until mgmt_miim_rdy=1).
- Accept on host_valid&host_ready (cycle 0):
  - latch opcode, addr, miim_sel, wdata into the mgmt_* outputs;
  - host_ready drops next cycle.
- ISSUE (cycle 1): mgmt_req=1 for exactly one cycle; mgmt_* fields held stable until the response.
- Non-MIIM path (state LAT):
  - count RD_LAT cycles after mgmt_req; mgmt_miim_rdy is ignored.
  - On the cycle mgmt_req+RD_LAT, capture mgmt_rd_data if read (else 0).
  - host_rvalid=1 at cycle 2+RD_LAT; total latency from accept = RD_LAT+2.
- MIIM path:
  - WAIT_LOW: wait for mgmt_miim_rdy=0. If not seen within RDY_LOW_WAIT cycles, go directly to CAPTURE (treated as an instantly completed op).
  - WAIT_HIGH: wait for mgmt_miim_rdy=1.
  - CAPTURE: sample mgmt_rd_data on the cycle rdy is first seen high (reads; writes/address ops give 0).
  - RESP: host_rvalid next cycle.
- RESP:
  - host_rvalid=1 for one cycle with host_rdata/host_rerr; host_rdata holds until the next response.
  - host_rerr=0 except on timeout.
  - Return to IDLE the following cycle. No host back-pressure on responses.
- host_valid while busy is ignored (not queued). Host must hold the request until accepted.
- Timeout counter saturates; it never wraps.

Optional Feature:
- Macro: MGMT_HOST_TIMEOUT_EN.
- Defined:
  - a 16-bit counter starts at mgmt_req on MIIM accesses and increments each cycle in WAIT_LOW/WAIT_HIGH;
  - on reaching TIMEOUT_CYC, go to RESP with host_rerr=1 and host_rdata=0;
  - mgmt_* outputs return to 0; the bridge re-enters IDLE; host_ready stays 0 until mgmt_miim_rdy=1.
- Not defined: no counter; host_rerr tied 0; MIIM transactions wait indefinitely for mgmt_miim_rdy.

Test Plan:
- Config write: opcode=01, addr=0x240, miim_sel=0, wdata=0xDEADBEEF, RD_LAT=2 → mgmt_req pulses once in cycle 1 with those fields; host_rvalid at cycle 4, rdata=0, rerr=0.
- Stats read: opcode=10, addr=0x200, model returns 0x00001234 two cycles after req → host_rdata=0x00001234 with host_rvalid at cycle 4.
- MDIO read: miim_sel=1, opcode=10; model drops rdy 1 cycle after req, raises it 70 cycles later with rd_data=0x0000ABCD → rvalid exactly 1 cycle after rdy rises, rdata=0x0000ABCD; host_ready=0 throughout.
- Back-to-back: host_valid held high with 3 requests → exactly 3 mgmt_req pulses, never two in consecutive responses without an intervening RESP/IDLE; second request ignored while busy.
- Timeout (macro on, TIMEOUT_CYC=16): MIIM op where rdy stays 0 → rvalid with rerr=1, rdata=0 at req+16+1; host_ready stays 0 until rdy=1.
- Reset mid-MIIM in WAIT_HIGH → next cycle all outputs 0, no rvalid, bridge accepts a new request once rdy=1.

Source files
------------

// File: rtl/mgmt_host_bridge_if.sv
// Host request/response channel plus management-port signals of mgmt_host_bridge.
// slave = bridge side, master = host/management-block side.
interface mgmt_host_bridge_if;
  logic        host_valid;
  logic        host_ready;
  logic [1:0]  host_opcode;
  logic [9:0]  host_addr;
  logic        host_miim_sel;
  logic [31:0] host_wdata;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        host_rerr;
  logic [1:0]  mgmt_opcode;
  logic [9:0]  mgmt_addr;
  logic [31:0] mgmt_wr_data;
  logic        mgmt_miim_sel;
  logic        mgmt_req;
  logic [31:0] mgmt_rd_data;
  logic        mgmt_miim_rdy;

  modport slave (
    input  host_valid, host_opcode, host_addr, host_miim_sel, host_wdata,
           mgmt_rd_data, mgmt_miim_rdy,
    output host_ready, host_rvalid, host_rdata, host_rerr,
           mgmt_opcode, mgmt_addr, mgmt_wr_data, mgmt_miim_sel, mgmt_req
  );

  modport master (
    output host_valid, host_opcode, host_addr, host_miim_sel, host_wdata,
           mgmt_rd_data, mgmt_miim_rdy,
    input  host_ready, host_rvalid, host_rdata, host_rerr,
           mgmt_opcode, mgmt_addr, mgmt_wr_data, mgmt_miim_sel, mgmt_req
  );
endinterface

// File: rtl/mgmt_host_bridge.sv
// Host valid/ready -> 10G MAC management port bridge, one transaction in flight.
// Optional MIIM completion timeout enabled by defining MGMT_HOST_TIMEOUT_EN.
module mgmt_host_bridge #(
  parameter int RD_LAT       = 2,
  parameter int RDY_LOW_WAIT = 4,
  parameter int TIMEOUT_CYC  = 4096
) (
  input logic               mgmt_clk,
  input logic               reset,
  mgmt_host_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, LAT, WAIT_LOW, WAIT_HIGH, RESP} state_t;

  state_t      state;
  logic [15:0] cnt;       // cycles elapsed since the mgmt_req cycle
  logic [15:0] cnt_inc;
  logic [31:0] cap_data;
  logic        done;
  logic        tmo;
  logic        tmo_hit;

  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign cap_data = bus.mgmt_opcode[1] ? bus.mgmt_rd_data : 32'd0;

`ifdef MGMT_HOST_TIMEOUT_EN
  assign tmo = (cnt >= 16'(TIMEOUT_CYC));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    done = 1'b0;
    case (state)
      LAT:       done = (cnt >= 16'(RD_LAT));
      // rdy never dropped: the op is treated as already complete
      WAIT_LOW:  done = bus.mgmt_miim_rdy && (cnt >= 16'(RDY_LOW_WAIT));
      WAIT_HIGH: done = bus.mgmt_miim_rdy;
      default:   done = 1'b0;
    endcase
  end

  assign tmo_hit = tmo && !done && (state == WAIT_LOW || state == WAIT_HIGH);

  always_ff @(posedge mgmt_clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.host_ready    <= 1'b0;
      bus.host_rvalid   <= 1'b0;
      bus.host_rdata    <= '0;
      bus.host_rerr     <= 1'b0;
      bus.mgmt_req      <= 1'b0;
      bus.mgmt_opcode   <= '0;
      bus.mgmt_addr     <= '0;
      bus.mgmt_wr_data  <= '0;
      bus.mgmt_miim_sel <= 1'b0;
    end else begin
      bus.mgmt_req    <= 1'b0;
      bus.host_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.host_valid && bus.host_ready) begin
            bus.mgmt_opcode   <= bus.host_opcode;
            bus.mgmt_addr     <= bus.host_addr;
            bus.mgmt_wr_data  <= bus.host_wdata;
            bus.mgmt_miim_sel <= bus.host_miim_sel;
            // ready may have been one cycle stale: hold the pulse until rdy
            bus.mgmt_req      <= bus.mgmt_miim_rdy;
            bus.host_ready    <= 1'b0;
            state             <= ISSUE;
          end else begin
            bus.host_ready <= bus.mgmt_miim_rdy;
          end
        end
        ISSUE: begin
          if (bus.mgmt_req) begin
            cnt   <= 16'd1;
            state <= bus.mgmt_miim_sel ? WAIT_LOW : LAT;
          end else if (bus.mgmt_miim_rdy) begin
            bus.mgmt_req <= 1'b1;
          end
        end
        LAT: cnt <= cnt_inc;
        WAIT_LOW: begin
          cnt <= cnt_inc;
          if (!bus.mgmt_miim_rdy) state <= WAIT_HIGH;
        end
        WAIT_HIGH: cnt <= cnt_inc;
        RESP: begin
          state          <= IDLE;
          bus.host_ready <= bus.mgmt_miim_rdy;
        end
        default: state <= IDLE;
      endcase

      if (done) begin
        bus.host_rvalid <= 1'b1;
        bus.host_rdata  <= cap_data;
        bus.host_rerr   <= 1'b0;
        state           <= RESP;
      end else if (tmo_hit) begin
        bus.host_rvalid   <= 1'b1;
        bus.host_rdata    <= '0;
        bus.host_rerr     <= 1'b1;
        bus.mgmt_opcode   <= '0;
        bus.mgmt_addr     <= '0;
        bus.mgmt_wr_data  <= '0;
        bus.mgmt_miim_sel <= 1'b0;
        state             <= RESP;
      end
    end
  end
endmodule

// File: tb/tb_mgmt_host_bridge.sv
// Directed bench for mgmt_host_bridge; timeout case runs when MGMT_HOST_TIMEOUT_EN is defined.
module tb_mgmt_host_bridge;
`ifdef MGMT_HOST_TIMEOUT_EN
  localparam int MDIO_HOLD = 10;
`else
  localparam int MDIO_HOLD = 70;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rd_val;
  logic        use_model;
  int          total = 0;
  int          bad = 0;

  mgmt_host_bridge_if bus ();

  always #5 clk = ~clk;

  // management-block read data: fixed value or address-derived model
  assign bus.mgmt_rd_data = use_model ? ({22'h0, bus.mgmt_addr} + 32'h100) : rd_val;

  mgmt_host_bridge #(.RD_LAT(2), .RDY_LOW_WAIT(4), .TIMEOUT_CYC(16)) dut (
    .mgmt_clk (clk),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // present a request for one edge; caller has checked host_ready. Returns in cycle 1.
  task automatic send(input logic [1:0] op, input logic [9:0] addr, input logic sel,
                      input logic [31:0] wdata);
    bus.host_valid    = 1'b1;
    bus.host_opcode   = op;
    bus.host_addr     = addr;
    bus.host_miim_sel = sel;
    bus.host_wdata    = wdata;
    tick();
    bus.host_valid    = 1'b0;
  endtask

  // current cycle counts as 1; returns the cycle index where host_rvalid is seen
  task automatic wait_rsp(input int budget, output int cyc, output int nreq, output int brdy);
    cyc  = 1;
    nreq = int'(bus.mgmt_req);
    brdy = int'(bus.host_ready);
    while (!bus.host_rvalid && cyc < budget) begin
      tick();
      cyc++;
      if (bus.mgmt_req) nreq++;
      if (bus.host_ready) brdy++;
    end
  endtask

  initial begin
    int cyc, nreq, brdy, busy;
    int n_acc, n_req, n_rsp, dbl;
    logic acc, prev_req;

    bus.host_valid    = 1'b0;
    bus.host_opcode   = '0;
    bus.host_addr     = '0;
    bus.host_miim_sel = 1'b0;
    bus.host_wdata    = '0;
    bus.mgmt_miim_rdy = 1'b1;
    rd_val            = 32'h0;
    use_model         = 1'b0;

    // reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_ready", 32'(bus.host_ready), 32'd0);
    chk("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst_rdata", bus.host_rdata, 32'd0);
    chk("rst_rerr", 32'(bus.host_rerr), 32'd0);
    chk("rst_mgmt", {19'h0, bus.mgmt_req, bus.mgmt_opcode, bus.mgmt_miim_sel, bus.mgmt_addr}, 32'd0);
    chk("rst_wdata", bus.mgmt_wr_data, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(bus.host_ready), 32'd1);

    // config write: rd_data is garbage and must not leak into the response
    rd_val = 32'hFFFF_FFFF;
    send(2'b01, 10'h240, 1'b0, 32'hDEAD_BEEF);
    chk("wr_req", 32'(bus.mgmt_req), 32'd1);
    chk("wr_fields", {19'h0, bus.mgmt_opcode, bus.mgmt_miim_sel, bus.mgmt_addr},
        {19'h0, 2'b01, 1'b0, 10'h240});
    chk("wr_wdata", bus.mgmt_wr_data, 32'hDEAD_BEEF);
    wait_rsp(40, cyc, nreq, brdy);
    chk("wr_lat", 32'(cyc), 32'd4);
    chk("wr_nreq", 32'(nreq), 32'd1);
    chk("wr_busy_ready", 32'(brdy), 32'd0);
    chk("wr_rdata", bus.host_rdata, 32'd0);
    chk("wr_rerr", 32'(bus.host_rerr), 32'd0);
    tick();
    chk("wr_rvalid_1cyc", 32'(bus.host_rvalid), 32'd0);
    chk("wr_ready_again", 32'(bus.host_ready), 32'd1);
    chk("wr_addr_held", 32'(bus.mgmt_addr), 32'h240);

    // stats read: data valid only in the capture cycle (req+2)
    rd_val = 32'hBAD0_0001;
    send(2'b10, 10'h200, 1'b0, 32'h0);
    tick();
    tick();
    rd_val = 32'h0000_1234;
    chk("rd_no_early_rvalid", 32'(bus.host_rvalid), 32'd0);
    tick();
    rd_val = 32'hBAD0_0002;
    chk("rd_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("rd_rdata", bus.host_rdata, 32'h0000_1234);
    tick();
    chk("rd_rdata_hold", bus.host_rdata, 32'h0000_1234);

    // stale ready: accepted while rdy has just dropped, waits in ISSUE
    bus.mgmt_miim_rdy = 1'b0;
    send(2'b01, 10'h3FF, 1'b0, 32'h1234_5678);
    busy = int'(bus.mgmt_req);
    tick(); busy += int'(bus.mgmt_req);
    tick(); busy += int'(bus.mgmt_req);
    chk("stale_no_req", 32'(busy), 32'd0);
    bus.mgmt_miim_rdy = 1'b1;
    tick();
    chk("stale_req", 32'(bus.mgmt_req), 32'd1);
    wait_rsp(40, cyc, nreq, brdy);
    chk("stale_lat", 32'(cyc), 32'd4);
    tick();

    // MDIO read: rdy low from req+1 for MDIO_HOLD cycles
    rd_val = 32'h0;
    send(2'b10, 10'h01F, 1'b1, 32'h0);
    chk("mdio_req", {30'h0, bus.mgmt_req, bus.mgmt_miim_sel}, 32'h3);
    tick();
    bus.mgmt_miim_rdy = 1'b0;
    busy = 0;
    for (int i = 0; i < MDIO_HOLD - 1; i++) begin
      tick();
      busy += int'(bus.host_ready) + int'(bus.host_rvalid) + int'(bus.mgmt_req);
    end
    tick();
    bus.mgmt_miim_rdy = 1'b1;
    rd_val = 32'h0000_ABCD;
    busy += int'(bus.host_ready) + int'(bus.host_rvalid);
    chk("mdio_busy", 32'(busy), 32'd0);
    tick();
    rd_val = 32'h0;
    chk("mdio_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("mdio_rdata", bus.host_rdata, 32'h0000_ABCD);
    chk("mdio_ready_resp", 32'(bus.host_ready), 32'd0);
    tick();
    chk("mdio_ready_after", 32'(bus.host_ready), 32'd1);

    // MIIM op where rdy never drops: completes after RDY_LOW_WAIT
    rd_val = 32'h0000_5555;
    send(2'b10, 10'h021, 1'b1, 32'h0);
    wait_rsp(40, cyc, nreq, brdy);
    chk("skip_lat", 32'(cyc), 32'd6);
    chk("skip_rdata", bus.host_rdata, 32'h0000_5555);
    tick();

    // back-to-back: host_valid held high across three requests
    use_model = 1'b1;
    n_acc = 0; n_req = 0; n_rsp = 0; dbl = 0; prev_req = 1'b0;
    bus.host_valid = 1'b1; bus.host_opcode = 2'b10; bus.host_miim_sel = 1'b0;
    bus.host_addr = 10'h010;
    for (int c = 0; c < 30; c++) begin
      acc = bus.host_valid && bus.host_ready;
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc == 3) bus.host_valid = 1'b0;
        else bus.host_addr = 10'(10'h010 + n_acc);
      end
      if (bus.mgmt_req) begin
        if (prev_req || n_req != n_rsp) dbl++;
        chk("b2b_addr", 32'(bus.mgmt_addr), 32'(10'h010 + n_req));
        n_req++;
      end
      prev_req = bus.mgmt_req;
      if (bus.host_rvalid) begin
        chk("b2b_rdata", bus.host_rdata, 32'h110 + 32'(n_rsp));
        n_rsp++;
      end
    end
    bus.host_valid = 1'b0;
    chk("b2b_nreq", 32'(n_req), 32'd3);
    chk("b2b_nrsp", 32'(n_rsp), 32'd3);
    chk("b2b_overlap", 32'(dbl), 32'd0);
    use_model = 1'b0;

`ifdef MGMT_HOST_TIMEOUT_EN
    // timeout: rdy stuck low
    send(2'b10, 10'h02A, 1'b1, 32'h0);
    bus.mgmt_miim_rdy = 1'b0;
    wait_rsp(60, cyc, nreq, brdy);
    chk("tmo_lat", 32'(cyc), 32'd18);
    chk("tmo_rerr", 32'(bus.host_rerr), 32'd1);
    chk("tmo_rdata", bus.host_rdata, 32'd0);
    chk("tmo_mgmt_clr", {21'h0, bus.mgmt_miim_sel, bus.mgmt_addr}, 32'd0);
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      busy += int'(bus.host_ready) + int'(bus.host_rvalid);
    end
    chk("tmo_ready_low", 32'(busy), 32'd0);
    bus.mgmt_miim_rdy = 1'b1;
    tick();
    chk("tmo_ready_back", 32'(bus.host_ready), 32'd1);
`endif

    // reset while waiting for rdy to rise
    rd_val = 32'h0;
    send(2'b10, 10'h155, 1'b1, 32'hCAFE_0001);
    bus.mgmt_miim_rdy = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("mrst_mgmt", {19'h0, bus.mgmt_req, bus.mgmt_opcode, bus.mgmt_miim_sel, bus.mgmt_addr}, 32'd0);
    chk("mrst_wdata", bus.mgmt_wr_data, 32'd0);
    chk("mrst_host", {29'h0, bus.host_ready, bus.host_rvalid, bus.host_rerr}, 32'd0);
    chk("mrst_rdata", bus.host_rdata, 32'd0);
    reset = 1'b0;
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      busy += int'(bus.host_ready) + int'(bus.host_rvalid);
    end
    chk("mrst_quiet", 32'(busy), 32'd0);
    bus.mgmt_miim_rdy = 1'b1;
    tick();
    chk("mrst_ready", 32'(bus.host_ready), 32'd1);
    use_model = 1'b1;
    send(2'b10, 10'h0AA, 1'b0, 32'h0);
    wait_rsp(40, cyc, nreq, brdy);
    chk("mrst_new_lat", 32'(cyc), 32'd4);
    chk("mrst_new_rdata", bus.host_rdata, 32'h0000_01AA);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
